// File: rtl/mini_cpu_pkg.sv
// Shared encodings for the mini-CPU instruction sequencer: opcodes, memory
// operations, display commands and sequencer states. The MUL opcode is only
// legal when MINI_CPU_MUL_EN is defined.
package mini_cpu_pkg;

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    localparam logic [1:0] MEM_IDLE  = 2'd0;
    localparam logic [1:0] MEM_GET   = 2'd1;
    localparam logic [1:0] MEM_SET   = 2'd2;
    localparam logic [1:0] MEM_RESET = 2'd3;

    localparam logic [1:0] DISP_OFF = 2'd0;
    localparam logic [1:0] DISP_ON  = 2'd1;
    localparam logic [1:0] DISP_UPD = 2'd2;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD1  = 3'd1;
    localparam logic [2:0] ST_RD2  = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_CLR  = 3'd5;
    localparam logic [2:0] ST_RDBK = 3'd6;
    localparam logic [2:0] ST_SHOW = 3'd7;

`ifdef MINI_CPU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // ADD and SUB take their second operand from memory; all other
    // arithmetic ops use the zero-extended immediate instead.
    function automatic logic uses_src2(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mini_cpu_alu.sv
// Combinational ALU for the mini-CPU sequencer. Unsigned arithmetic modulo
// 2**DATA_W; carry is the add carry-out, the subtract borrow, or (only when
// MINI_CPU_MUL_EN is defined) a nonzero upper half of the product.
module mini_cpu_alu
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] r,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

`ifdef MINI_CPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    // Select the result and the carry/borrow/overflow flag for the opcode.
    always_comb begin
        r     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: begin
                r     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB, OP_SUBI: begin
                r     = diff[DATA_W-1:0];
                carry = diff[DATA_W];
            end
`ifdef MINI_CPU_MUL_EN
            OP_MUL: begin
                r     = prod[DATA_W-1:0];
                carry = |prod[2*DATA_W-1:DATA_W];
            end
`endif
            default: begin
                r     = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mini_cpu_seq.sv
// Mini-CPU instruction sequencer: accepts one instruction per handshake,
// reads operands from the external word memory, computes in mini_cpu_alu,
// writes back, reads the destination back and shows it on the display.
// Define MINI_CPU_MUL_EN to enable the MUL opcode; otherwise MUL is illegal.
module mini_cpu_seq
    import mini_cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic [IMM_W-1:0]  imm,
    output logic [1:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic [1:0]        disp_cmd,
    input  logic              disp_done,
    output logic [2:0]        disp_opcode,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy,
    output logic              carry,
    output logic              err
);

    logic [2:0]        state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src2_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_r;
    logic              alu_carry;
    logic              accept;
    logic              legal;

    assign instr_ready = (state == ST_IDLE);
    assign busy        = ~instr_ready;
    assign accept      = instr_valid & instr_ready;
    assign legal       = MUL_EN || (opcode != OP_MUL);
    assign disp_opcode = op_q;
    assign disp_addr   = dst_q;

    mini_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .r     (alu_r),
        .carry (alu_carry)
    );

    // Sequencer: every memory/display request is registered and held until
    // its done strobe is sampled, which is also the cycle that moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            src2_q    <= '0;
            imm_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mem_op    <= MEM_IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            disp_cmd  <= DISP_OFF;
            disp_data <= '0;
            carry     <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && !legal) begin
                        err <= 1'b1;
                    end else if (accept) begin
                        op_q   <= opcode;
                        dst_q  <= dst;
                        src2_q <= src2;
                        imm_q  <= imm;
                        case (opcode)
                            OP_LOAD: begin
                                state     <= ST_WR;
                                mem_op    <= MEM_SET;
                                mem_addr  <= dst;
                                mem_wdata <= DATA_W'(imm);
                            end
                            OP_CLEAR: begin
                                state    <= ST_CLR;
                                mem_op   <= MEM_RESET;
                                mem_addr <= dst;
                            end
                            OP_DISPLAY: begin
                                state    <= ST_RDBK;
                                mem_op   <= MEM_GET;
                                mem_addr <= dst;
                            end
                            default: begin
                                state    <= ST_RD1;
                                mem_op   <= MEM_GET;
                                mem_addr <= src1;
                            end
                        endcase
                    end
                end
                ST_RD1: begin
                    if (mem_done) begin
                        a_q <= mem_rdata;
                        if (uses_src2(op_q)) begin
                            state    <= ST_RD2;
                            mem_addr <= src2_q;
                        end else begin
                            b_q    <= DATA_W'(imm_q);
                            state  <= ST_EXEC;
                            mem_op <= MEM_IDLE;
                        end
                    end
                end
                ST_RD2: begin
                    if (mem_done) begin
                        b_q    <= mem_rdata;
                        state  <= ST_EXEC;
                        mem_op <= MEM_IDLE;
                    end
                end
                ST_EXEC: begin
                    carry     <= alu_carry;
                    state     <= ST_WR;
                    mem_op    <= MEM_SET;
                    mem_addr  <= dst_q;
                    mem_wdata <= alu_r;
                end
                ST_WR, ST_CLR: begin
                    if (mem_done) begin
                        if (state == ST_CLR) begin
                            carry <= 1'b0;
                        end
                        state    <= ST_RDBK;
                        mem_op   <= MEM_GET;
                        mem_addr <= dst_q;
                    end
                end
                ST_RDBK: begin
                    if (mem_done) begin
                        disp_data <= mem_rdata;
                        state     <= ST_SHOW;
                        mem_op    <= MEM_IDLE;
                        disp_cmd  <= DISP_UPD;
                    end
                end
                ST_SHOW: begin
                    if (disp_done) begin
                        state    <= ST_IDLE;
                        disp_cmd <= DISP_ON;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    mem_op <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule
